// File: rtl/avalon_crossbar.sv
// Avalon-MM crossbar: masters reach address-decoded slaves through
// per-slave round-robin arbiters with one cycle of grant latency.
module avalon_crossbar #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter logic [5*NUM_SLAVES-1:0] SEL_NUM_BITS = {5'd1, 5'd1},
  parameter logic [ADDR_W*NUM_SLAVES-1:0] SEL_VAL = {30'd1, 30'd0}
) (
  input  logic                              i_Clk,
  input  logic                              i_Reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     i_AVIn_Addr,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] i_AVIn_ByteEn,
  input  logic [NUM_MASTERS-1:0]            i_AVIn_Read,
  input  logic [NUM_MASTERS-1:0]            i_AVIn_Write,
  input  logic [NUM_MASTERS*DATA_W-1:0]     i_AVIn_WriteData,
  output logic [NUM_MASTERS*DATA_W-1:0]     o_AVIn_ReadData,
  output logic [NUM_MASTERS-1:0]            o_AVIn_WaitRequest,
  output logic [NUM_MASTERS-1:0]            o_AVIn_DecodeErr,
  output logic [NUM_SLAVES*ADDR_W-1:0]      o_AVOut_Addr,
  output logic [NUM_SLAVES*(DATA_W/8)-1:0]  o_AVOut_ByteEn,
  output logic [NUM_SLAVES-1:0]             o_AVOut_Read,
  output logic [NUM_SLAVES-1:0]             o_AVOut_Write,
  output logic [NUM_SLAVES*DATA_W-1:0]      o_AVOut_WriteData,
  input  logic [NUM_SLAVES*DATA_W-1:0]      i_AVOut_ReadData,
  input  logic [NUM_SLAVES-1:0]             i_AVOut_WaitRequest
);

  localparam int BE_W = DATA_W / 8;
  localparam int MW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_t;

  logic [NUM_MASTERS*NUM_SLAVES-1:0] w_hit;
  logic [NUM_SLAVES-1:0]  w_tgt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_mapped;
  logic [NUM_MASTERS-1:0] w_busy;
  logic [NUM_MASTERS-1:0] w_unmap;
  logic [NUM_MASTERS-1:0] w_pick [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]  w_greq;
  logic [MW-1:0]          w_idx;

  state_t                 r_state [NUM_SLAVES];
  logic [NUM_MASTERS-1:0] r_grant [NUM_SLAVES];
  logic [MW-1:0]          r_ptr   [NUM_SLAVES];
  logic [NUM_MASTERS-1:0] r_derr;

  assign w_req = i_AVIn_Read | i_AVIn_Write;

  // Raw address match of every master against every slave window
  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_m
    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_s
      localparam int NR = int'(SEL_NUM_BITS[5*s +: 5]);
      localparam int N  = (NR > ADDR_W) ? ADDR_W : NR;
      localparam logic [ADDR_W-1:0] V = SEL_VAL[ADDR_W*s +: ADDR_W];
      if (N == 0) begin : g_all
        assign w_hit[m*NUM_SLAVES+s] = 1'b1;
      end else begin : g_cmp
        assign w_hit[m*NUM_SLAVES+s] =
          (i_AVIn_Addr[m*ADDR_W+ADDR_W-1 -: N] == V[N-1:0]);
      end
    end
  end

  // Lowest matching slave index wins
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_tgt[m] = '0;
      for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
        if (w_hit[m*NUM_SLAVES+s]) begin
          w_tgt[m]    = '0;
          w_tgt[m][s] = 1'b1;
        end
      end
      w_mapped[m] = |w_tgt[m];
    end
  end

  always_comb begin
    w_busy = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_busy = w_busy | r_grant[s];
    end
  end

  assign w_unmap = w_req & ~w_mapped & ~w_busy & ~r_derr;

  // Round-robin pick: first eligible master after the pointer
  always_comb begin
    w_idx = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_pick[s] = '0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        w_idx = MW'((int'(r_ptr[s]) + k) % NUM_MASTERS);
        if (w_req[w_idx] && w_tgt[w_idx][s] && !w_busy[w_idx]) begin
          w_pick[s]        = '0;
          w_pick[s][w_idx] = 1'b1;
        end
      end
      w_greq[s] = |(r_grant[s] & w_req);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_derr <= '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        r_state[s] <= ST_IDLE;
        r_grant[s] <= '0;
        r_ptr[s]   <= MW'(NUM_MASTERS - 1);
      end
    end else begin
      r_derr <= w_unmap;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        unique case (r_state[s])
          ST_IDLE: begin
            if (|w_pick[s]) begin
              r_grant[s] <= w_pick[s];
              r_state[s] <= ST_OWNED;
            end
          end
          ST_OWNED: begin
            if (!w_greq[s]) begin
              r_grant[s] <= '0;
              r_state[s] <= ST_IDLE;
            end else if (!i_AVOut_WaitRequest[s]) begin
              for (int m = 0; m < NUM_MASTERS; m++) begin
                if (r_grant[s][m]) r_ptr[s] <= MW'(m);
              end
              r_grant[s] <= '0;
              r_state[s] <= ST_IDLE;
            end
          end
          default: begin
            r_grant[s] <= '0;
            r_state[s] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Owned slaves mirror their master; reset forces idle outputs at once
  always_comb begin
    o_AVIn_WaitRequest = '1;
    o_AVIn_ReadData    = '0;
    o_AVIn_DecodeErr   = '0;
    o_AVOut_Addr       = '0;
    o_AVOut_ByteEn     = '0;
    o_AVOut_Read       = '0;
    o_AVOut_Write      = '0;
    o_AVOut_WriteData  = '0;
    if (!i_Reset) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (r_derr[m]) begin
          o_AVIn_WaitRequest[m] = 1'b0;
          o_AVIn_DecodeErr[m]   = 1'b1;
        end
      end
      for (int s = 0; s < NUM_SLAVES; s++) begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
          if (r_state[s] == ST_OWNED && r_grant[s][m]) begin
            o_AVOut_Addr[s*ADDR_W +: ADDR_W] =
              i_AVIn_Addr[m*ADDR_W +: ADDR_W];
            o_AVOut_ByteEn[s*BE_W +: BE_W] =
              i_AVIn_ByteEn[m*BE_W +: BE_W];
            o_AVOut_WriteData[s*DATA_W +: DATA_W] =
              i_AVIn_WriteData[m*DATA_W +: DATA_W];
            o_AVOut_Write[s] = i_AVIn_Write[m];
            o_AVOut_Read[s]  = i_AVIn_Read[m] & ~i_AVIn_Write[m];
            o_AVIn_WaitRequest[m] = i_AVOut_WaitRequest[s];
            o_AVIn_ReadData[m*DATA_W +: DATA_W] =
              i_AVOut_ReadData[s*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule
